// File: rtl/microcode_loader_pkg.sv
// Shared constants for the two-level microcode store and its runtime loader.
// The store itself sizes its tables from the same depth/width constants.
package microcode_loader_pkg;

    localparam int OPC_DEPTH = 13;
    localparam int SUB_DEPTH = 10;
    localparam int CW_WIDTH  = 59;

    localparam logic [7:0] HDR_OPC = 8'h01;
    localparam logic [7:0] HDR_SUB = 8'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INDEX = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_t;

    typedef enum logic {
        TBL_OPC = 1'b0,
        TBL_SUB = 1'b1
    } tbl_t;

    // Counter value of the final data byte for the selected table.
    function automatic logic [2:0] last_byte(input tbl_t tbl);
        return (tbl == TBL_SUB) ? 3'd7 : 3'd0;
    endfunction

endpackage

// File: rtl/microcode_loader_if.sv
// Byte-stream input and table write-port bundle of the microcode loader.
interface microcode_loader_if;
    import microcode_loader_pkg::*;

    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic                lock;
    logic                opc_we;
    logic [3:0]          opc_addr;
    logic [3:0]          opc_wdata;
    logic                sub_we;
    logic [3:0]          sub_addr;
    logic [CW_WIDTH-1:0] sub_wdata;
    logic                err;
    logic                busy;

    modport master (
        output in_valid, in_data, lock,
        input  in_ready, opc_we, opc_addr, opc_wdata,
               sub_we, sub_addr, sub_wdata, err, busy
    );

    modport slave (
        input  in_valid, in_data, lock,
        output in_ready, opc_we, opc_addr, opc_wdata,
               sub_we, sub_addr, sub_wdata, err, busy
    );

endinterface

// File: rtl/microcode_loader.sv
// Framed byte-stream writer for the opcode index table and subop control-word table.
// Header, index, then 1 or 8 little-endian data bytes; one write strobe per good frame.
module microcode_loader #(
    parameter int OPC_DEPTH = microcode_loader_pkg::OPC_DEPTH,
    parameter int SUB_DEPTH = microcode_loader_pkg::SUB_DEPTH,
    parameter int CW_WIDTH  = microcode_loader_pkg::CW_WIDTH
) (
    input logic               clk,
    input logic               rst,
    microcode_loader_if.slave bus
);
    import microcode_loader_pkg::*;

    localparam logic [7:0] OPC_LIMIT = 8'(OPC_DEPTH);
    localparam logic [7:0] SUB_LIMIT = 8'(SUB_DEPTH);

    state_t              state_r;
    tbl_t                tbl_r;
    logic [3:0]          idx_r;
    logic [2:0]          cnt_r;
    logic [63:0]         asm_r;
    logic [63:0]         asm_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                opc_we_r;
    logic [3:0]          opc_addr_r;
    logic [3:0]          opc_wdata_r;
    logic                sub_we_r;
    logic [3:0]          sub_addr_r;
    logic [CW_WIDTH-1:0] sub_wdata_r;
    logic                err_r;

    // Assembly register with the incoming byte merged at the current byte lane.
    always_comb begin
        asm_s = asm_r;
        asm_s[{cnt_r, 3'b000} +: 8] = bus.in_data;
    end

    // Ready decode; lock only gates the start of a new frame.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:        in_ready_s = !bus.lock;
            INDEX, DATA: in_ready_s = 1'b1;
            WRITE:       in_ready_s = 1'b0;
            default:     in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = bus.in_valid && in_ready_s;

    // Frame FSM; the strobe is raised on the edge that accepts the last data
    // byte so that it is high during the WRITE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            tbl_r       <= TBL_OPC;
            idx_r       <= 4'd0;
            cnt_r       <= 3'd0;
            asm_r       <= 64'd0;
            opc_we_r    <= 1'b0;
            opc_addr_r  <= 4'd0;
            opc_wdata_r <= 4'd0;
            sub_we_r    <= 1'b0;
            sub_addr_r  <= 4'd0;
            sub_wdata_r <= '0;
            err_r       <= 1'b0;
        end else begin
            opc_we_r <= 1'b0;
            sub_we_r <= 1'b0;
            err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (bus.in_data == HDR_OPC) begin
                            tbl_r   <= TBL_OPC;
                            state_r <= INDEX;
                        end else if (bus.in_data == HDR_SUB) begin
                            tbl_r   <= TBL_SUB;
                            state_r <= INDEX;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                INDEX: begin
                    if (accept_s) begin
                        if ((tbl_r == TBL_OPC && bus.in_data < OPC_LIMIT) ||
                            (tbl_r == TBL_SUB && bus.in_data < SUB_LIMIT)) begin
                            idx_r   <= bus.in_data[3:0];
                            cnt_r   <= 3'd0;
                            asm_r   <= 64'd0;
                            state_r <= DATA;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        asm_r <= asm_s;
                        cnt_r <= cnt_r + 3'd1;
                        if (cnt_r == last_byte(tbl_r)) begin
                            state_r <= WRITE;
                            if (tbl_r == TBL_OPC) begin
                                opc_we_r    <= 1'b1;
                                opc_addr_r  <= idx_r;
                                opc_wdata_r <= asm_s[3:0];
                            end else begin
                                sub_we_r    <= 1'b1;
                                sub_addr_r  <= idx_r;
                                sub_wdata_r <= asm_s[CW_WIDTH-1:0];
                            end
                        end
                    end
                end
                WRITE:   state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.opc_we    = opc_we_r;
    assign bus.opc_addr  = opc_addr_r;
    assign bus.opc_wdata = opc_wdata_r;
    assign bus.sub_we    = sub_we_r;
    assign bus.sub_addr  = sub_addr_r;
    assign bus.sub_wdata = sub_wdata_r;
    assign bus.err       = err_r;
    assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_microcode_loader.sv
// Directed self-checking bench for microcode_loader: one task per scenario.
module tb_microcode_loader;
    import microcode_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_opc_we = 0;
    int   n_sub_we = 0;
    int   n_err    = 0;

    logic [7:0]  sub_bytes [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'hF1};
    logic [58:0] sub_exp = 59'h1_2345_6789_ABCD_EF;

    microcode_loader_if bus ();

    microcode_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse counters, updated at the sampling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.opc_we) n_opc_we <= n_opc_we + 1;
            if (bus.sub_we) n_sub_we <= n_sub_we + 1;
            if (bus.err)    n_err    <= n_err + 1;
        end
    end

    // Present one byte from a negedge until it is accepted; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!acc && tries < 20) begin
            #1 acc = bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            tries++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: byte %h not accepted in %0d cycles", b, tries);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.lock = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.opc_we !== 1'b0) begin n_fail++; $display("FAIL rst_opc_we: got %b want 0", bus.opc_we); end
        n_vec++; if (bus.sub_we !== 1'b0) begin n_fail++; $display("FAIL rst_sub_we: got %b want 0", bus.sub_we); end
        n_vec++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.opc_addr !== 4'd0 || bus.opc_wdata !== 4'd0) begin n_fail++; $display("FAIL rst_opc_regs: got %h/%h want 0/0", bus.opc_addr, bus.opc_wdata); end
        n_vec++; if (bus.sub_addr !== 4'd0 || bus.sub_wdata !== 59'd0) begin n_fail++; $display("FAIL rst_sub_regs: got %h/%h want 0/0", bus.sub_addr, bus.sub_wdata); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_opcode_load();
        send_byte(8'h01); send_byte(8'h05); send_byte(8'h0A);
        n_vec++; if (bus.opc_we !== 1'b1) begin n_fail++; $display("FAIL opc_we: got %b want 1", bus.opc_we); end
        n_vec++; if (bus.opc_addr !== 4'd5) begin n_fail++; $display("FAIL opc_addr: got %h want 5", bus.opc_addr); end
        n_vec++; if (bus.opc_wdata !== 4'hA) begin n_fail++; $display("FAIL opc_wdata: got %h want a", bus.opc_wdata); end
        n_vec++; if (bus.sub_we !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL opc_other: got sub_we %b err %b want 0 0", bus.sub_we, bus.err); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL opc_write_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        n_vec++; if (bus.opc_we !== 1'b0) begin n_fail++; $display("FAIL opc_we_pulse: got %b want 0", bus.opc_we); end
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL opc_busy_after: got %b want 0", bus.busy); end
        n_vec++; if (bus.opc_addr !== 4'd5 || bus.opc_wdata !== 4'hA) begin n_fail++; $display("FAIL opc_hold: got %h/%h want 5/a", bus.opc_addr, bus.opc_wdata); end
        // Highest legal index, upper nibble of data ignored.
        send_byte(8'h01); send_byte(8'h0C); send_byte(8'hF3);
        n_vec++; if (bus.opc_we !== 1'b1 || bus.opc_addr !== 4'd12 || bus.opc_wdata !== 4'h3) begin
            n_fail++; $display("FAIL opc_edge: got we %b addr %h data %h want 1 c 3", bus.opc_we, bus.opc_addr, bus.opc_wdata); end
        @(negedge clk);
    endtask

    task automatic test_subop_load();
        int opc_before;
        opc_before = n_opc_we;
        send_byte(8'h02); send_byte(8'h03);
        for (int i = 0; i < 8; i++) send_byte(sub_bytes[i]);
        n_vec++; if (bus.sub_we !== 1'b1) begin n_fail++; $display("FAIL sub_we: got %b want 1", bus.sub_we); end
        n_vec++; if (bus.sub_addr !== 4'd3) begin n_fail++; $display("FAIL sub_addr: got %h want 3", bus.sub_addr); end
        n_vec++; if (bus.sub_wdata !== sub_exp) begin n_fail++; $display("FAIL sub_wdata: got %h want %h", bus.sub_wdata, sub_exp); end
        n_vec++; if (bus.opc_we !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sub_write_cycle: got opc_we %b in_ready %b want 0 0", bus.opc_we, bus.in_ready); end
        @(negedge clk);
        n_vec++; if (bus.sub_we !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL sub_after: got sub_we %b busy %b want 0 0", bus.sub_we, bus.busy); end
        n_vec++; if (bus.opc_addr !== 4'd12) begin n_fail++; $display("FAIL sub_opc_hold: got %h want c", bus.opc_addr); end
        #1;
        n_vec++; if (n_opc_we !== opc_before) begin n_fail++; $display("FAIL sub_no_opc: got %0d opc strobes want %0d", n_opc_we, opc_before); end
    endtask

    task automatic test_bad_header();
        int err_before, we_before;
        err_before = n_err;
        we_before  = n_opc_we + n_sub_we;
        send_byte(8'h07);
        n_vec++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bad_hdr_err: got err %b busy %b want 1 0", bus.err, bus.busy); end
        send_byte(8'h01);
        n_vec++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL bad_hdr_recover: got err %b busy %b want 0 1", bus.err, bus.busy); end
        send_byte(8'h02); send_byte(8'h05);
        n_vec++; if (bus.opc_we !== 1'b1 || bus.opc_addr !== 4'd2 || bus.opc_wdata !== 4'h5) begin
            n_fail++; $display("FAIL bad_hdr_frame: got we %b addr %h data %h want 1 2 5", bus.opc_we, bus.opc_addr, bus.opc_wdata); end
        @(negedge clk); #1;
        n_vec++; if (n_err !== err_before + 1 || n_opc_we + n_sub_we !== we_before + 1) begin
            n_fail++; $display("FAIL bad_hdr_counts: got err %0d we %0d want %0d %0d", n_err, n_opc_we + n_sub_we, err_before + 1, we_before + 1); end
    endtask

    task automatic test_bad_index();
        int we_before;
        we_before = n_opc_we + n_sub_we;
        send_byte(8'h02); send_byte(8'h0A);
        n_vec++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bad_sub_idx: got err %b busy %b want 1 0", bus.err, bus.busy); end
        send_byte(8'h01); send_byte(8'h0D);
        n_vec++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bad_opc_idx: got err %b busy %b want 1 0", bus.err, bus.busy); end
        // Next byte must be treated as a header, not as data of the rejected frame.
        send_byte(8'h01);
        n_vec++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL bad_idx_rehdr: got busy %b err %b want 1 0", bus.busy, bus.err); end
        send_byte(8'h00); send_byte(8'h0E);
        n_vec++; if (bus.opc_we !== 1'b1 || bus.opc_addr !== 4'd0 || bus.opc_wdata !== 4'hE) begin
            n_fail++; $display("FAIL bad_idx_frame: got we %b addr %h data %h want 1 0 e", bus.opc_we, bus.opc_addr, bus.opc_wdata); end
        @(negedge clk); #1;
        n_vec++; if (n_opc_we + n_sub_we !== we_before + 1) begin n_fail++; $display("FAIL bad_idx_strobes: got %0d want %0d", n_opc_we + n_sub_we, we_before + 1); end
    endtask

    task automatic test_gaps();
        idle(2); send_byte(8'h02);
        idle(3); send_byte(8'h09);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            n_vec++; if (i > 0 && bus.sub_we !== 1'b0) begin n_fail++; $display("FAIL gap_early_we: got %b want 0 before byte %0d", bus.sub_we, i); end
            send_byte(sub_bytes[i]);
        end
        n_vec++; if (bus.sub_we !== 1'b1 || bus.sub_addr !== 4'd9 || bus.sub_wdata !== sub_exp) begin
            n_fail++; $display("FAIL gap_result: got we %b addr %h data %h want 1 9 %h", bus.sub_we, bus.sub_addr, bus.sub_wdata, sub_exp); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL gap_write_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_lock();
        bus.lock = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lock_ready: got %b want 0", bus.in_ready); end
        repeat (3) @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL lock_no_start: got busy %b want 0", bus.busy); end
        bus.in_valid = 1'b0;
        bus.lock = 1'b0;
        send_byte(8'h01);
        bus.lock = 1'b1;
        send_byte(8'h04); send_byte(8'h06);
        n_vec++; if (bus.opc_we !== 1'b1 || bus.opc_addr !== 4'd4 || bus.opc_wdata !== 4'h6) begin
            n_fail++; $display("FAIL lock_mid_frame: got we %b addr %h data %h want 1 4 6", bus.opc_we, bus.opc_addr, bus.opc_wdata); end
        @(negedge clk); #1;
        n_vec++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL lock_idle_after: got ready %b busy %b want 0 0", bus.in_ready, bus.busy); end
        bus.lock = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int sub_before;
        sub_before = n_sub_we;
        send_byte(8'h02); send_byte(8'h01);
        send_byte(8'hEF); send_byte(8'hCD); send_byte(8'hAB);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0 || bus.sub_we !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ctrl: got busy %b sub_we %b err %b want 0 0 0", bus.busy, bus.sub_we, bus.err); end
        n_vec++; if (bus.opc_addr !== 4'd0 || bus.opc_wdata !== 4'd0 || bus.sub_addr !== 4'd0 || bus.sub_wdata !== 59'd0) begin
            n_fail++; $display("FAIL rstmid_regs: got %h %h %h %h want all 0", bus.opc_addr, bus.opc_wdata, bus.sub_addr, bus.sub_wdata); end
        rst = 1'b0;
        idle(3);
        send_byte(8'h01); send_byte(8'h07); send_byte(8'h09);
        n_vec++; if (bus.opc_we !== 1'b1 || bus.opc_addr !== 4'd7 || bus.opc_wdata !== 4'h9) begin
            n_fail++; $display("FAIL rstmid_fresh: got we %b addr %h data %h want 1 7 9", bus.opc_we, bus.opc_addr, bus.opc_wdata); end
        @(negedge clk); #1;
        n_vec++; if (n_sub_we !== sub_before) begin n_fail++; $display("FAIL rstmid_no_sub: got %0d sub strobes want %0d", n_sub_we, sub_before); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.lock     = 1'b0;
        @(negedge clk);
        test_reset();
        test_opcode_load();
        test_subop_load();
        test_bad_header();
        test_bad_index();
        test_gaps();
        test_lock();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/microcode_loader.md
# microcode_loader

Runtime writer for the two-level microcode store: the opcode-to-subop index table (13 × 4 bit) and the subop control-word table (10 × 59 bit). It accepts a framed byte stream on a valid/ready handshake, assembles table entries, and issues single-cycle write strobes into the table RAMs. This lets the tables be loaded or patched from a debug/boot port instead of only from init files. It sits between the boot/debug byte source and the microcode store's write ports.

## Interface

Parameters:
- `OPC_DEPTH`, 13: opcode table entries; valid index is 0..OPC_DEPTH-1.
- `SUB_DEPTH`, 10: subop table entries; valid index is 0..SUB_DEPTH-1.
- `CW_WIDTH`, 59: control-word width in bits.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: source has a byte on `in_data`.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts the byte this cycle.
- `lock` in 1: when high, no new frame starts. A frame already in progress completes.
- `opc_we` out 1: one-cycle write strobe to the opcode table.
- `opc_addr` out 4: opcode table index.
- `opc_wdata` out 4: opcode table entry.
- `sub_we` out 1: one-cycle write strobe to the subop table.
- `sub_addr` out 4: subop table index.
- `sub_wdata` out CW_WIDTH: control word.
- `err` out 1: one-cycle pulse on a rejected frame.
- `busy` out 1: high in every state except IDLE.

## Operation

- A byte transfers when `in_valid && in_ready` in the same cycle.
- Frame format:
  - byte 0: header. 0x01 selects the opcode table; 0x02 selects the subop table.
  - byte 1: index.
  - then data bytes: 1 byte for the opcode table (bits [3:0] used, [7:4] ignored); 8 bytes little-endian for the subop table (bits [58:0] used, the upper 5 bits of byte 7 ignored).
- States: IDLE, INDEX, DATA, WRITE.
  - IDLE: `in_ready = !lock`. Header 0x01 or 0x02 latches the table select and goes to INDEX. Any other header pulses `err` next cycle and stays in IDLE.
  - INDEX: `in_ready = 1`. An in-range index is latched, the byte counter is cleared, and the FSM goes to DATA. An out-of-range index pulses `err` next cycle and returns to IDLE; no data bytes are consumed for that frame.
  - DATA: `in_ready = 1`. Byte k is shifted into bits [8k+7:8k] of the assembly register and the 3-bit counter increments. On the last byte (k = 0 for the opcode table, k = 7 for the subop table) the FSM goes to WRITE.
  - WRITE: `in_ready = 0`. The FSM asserts exactly one of `opc_we` / `sub_we` for one cycle, with address and data valid that same cycle, then returns to IDLE.
- `*_addr` and `*_wdata` hold their last values when the strobe is low. The assembly register is cleared on entry to DATA.
- `lock` is sampled only in IDLE.

## Timing

- Reset values: all strobes 0, `err` 0, `busy` 0, addresses 0, wdata 0, state IDLE. `in_ready` follows `lock` from the first post-reset cycle.
- Minimum frame length:
  - opcode frame: 3 accepted bytes + 1 WRITE cycle = 4 cycles.
  - subop frame: 10 accepted bytes + 1 WRITE cycle = 11 cycles.
- The write strobe is asserted in the cycle immediately after the last data byte is accepted.
- `in_valid` gaps stall the FSM in its current state; no timeout.
- `rst` mid-frame: the partial word is discarded, no strobe is issued, and the FSM is in IDLE on the next cycle.
- `err` and a write strobe are never high in the same cycle.

## Structure

- Shared package: header codes (0x01, 0x02), the state enum, OPC_DEPTH, SUB_DEPTH and CW_WIDTH. The microcode store reads the same depth and width constants from this package.
- No sub-module; the FSM, counter and shift register live in one module.

## Test plan

- Opcode load: stream 0x01, 0x05, 0x0A -> `opc_we` high 1 cycle, `opc_addr` = 5, `opc_wdata` = 0xA, `busy` low the next cycle.
- Subop load: stream 0x02, 0x03, 0xEF, 0xCD, 0xAB, 0x89, 0x67, 0x45, 0x23, 0xF1 -> `sub_we` high 1 cycle, `sub_addr` = 3, `sub_wdata` = 59'h1_2345_6789_ABCD_EF.
- Bad header: stream 0x07 -> `err` pulse, no strobe, next byte 0x01 starts a valid frame. Bad index: stream 0x02, 0x0A -> `err`, no strobe.
- Backpressure and gaps: randomly deassert `in_valid` during a subop frame -> identical result to the subop load; `in_ready` is low during WRITE.
- `lock`: with `lock` = 1 in IDLE, `in_ready` = 0. Raising `lock` mid-frame still completes the frame with its write strobe.
- Reset mid-frame: assert `rst` after the 5th subop byte -> no strobe, all outputs at reset values, and a fresh opcode frame then writes correctly.
